hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline hazard controller for the IF/ID/EX/MEM/WB core.
- Decides every cycle whether each pipeline register advances, holds, or is squashed:
  - load-use stall
  - taken-branch/jal/jalr flush
  - data-memory wait freeze
  - EX-operand forwarding selects
- Keeps saturating stall/flush performance counters next to the existing clock_cycles counter.

Parameters:
- REG_AW, 5, register-address width
- CNT_W, 11, width of the performance counters
- FLUSH_CYCLES, 2, number of squash cycles after a redirect (must be ≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX
- ex_rd  in  REG_AW  EX destination register
- ex_regwrite, ex_memread  in  1  EX control bits
- ex_redirect  in  1  branch taken, jal or jalr resolved in EX
- mem_rd  in  REG_AW; mem_regwrite  in  1  MEM-stage writer
- wb_rd  in  REG_AW; wb_regwrite  in  1  WB-stage writer
- dmem_req  in  1  MEM stage accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC register load enable
- ifid_we  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads all-zero control bits
- exmem_we  out  1  EX/MEM and MEM/WB load enable
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- state  out  2  00 RUN, 01 FLUSH, 10 MEM_WAIT
- stall_cycles, flush_cycles  out  CNT_W  performance counters

Behaviour:
- While rst=0, asynchronously:
  - state=RUN, flush count=0, saved state=RUN, both counters=0.
  - Outputs: pc_we=0, ifid_we=0, exmem_we=0, ifid_flush=1, idex_bubble=1, fwd_a/fwd_b=00.
- Default in RUN: pc_we=ifid_we=exmem_we=1, ifid_flush=idex_bubble=0.
- Hazard terms, all combinational:
  - ld_use = ex_memread & ex_regwrite & ex_rd≠0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))
  - dwait = dmem_req & ~dmem_ready
- Priority in every state: dwait > ex_redirect > ld_use.
- dwait (freeze):
  - Same cycle: pc_we=ifid_we=exmem_we=0, idex_bubble=0, ifid_flush=0.
  - Next state MEM_WAIT; the current state (RUN or FLUSH) and the remaining flush count are saved.
  - MEM_WAIT holds this freeze until the cycle dmem_ready=1. That cycle releases normally, evaluating ex_redirect/ld_use as if in the saved state. Next state is the saved state, or the redirect-driven state.
- ex_redirect (not dwait):
  - Same cycle: pc_we=1, ifid_flush=1, idex_bubble=1, ifid_we=1.
  - If FLUSH_CYCLES>1: next state FLUSH, count=FLUSH_CYCLES-1.
  - In FLUSH: same outputs each cycle, count decrements, return to RUN after the cycle where count==1.
  - A redirect arriving while in FLUSH reloads count=FLUSH_CYCLES-1.
- ld_use (RUN, no dwait, no redirect):
  - Same cycle: pc_we=0, ifid_we=0, idex_bubble=1; state stays RUN.
  - Exactly one bubble per load; a second consecutive ld_use is impossible because EX now holds the bubble.
  - ld_use is ignored in FLUSH, since the ID instruction is being squashed.
- Forwarding, combinational, independent of state:
  - fwd_a=10 if mem_regwrite & mem_rd≠0 & mem_rd==ex_rs1.
  - Else fwd_a=01 if wb_regwrite & wb_rd≠0 & wb_rd==ex_rs1.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rs2. MEM has priority over WB.
- Counters:
  - stall_cycles +1 each clock where pc_we=0.
  - flush_cycles +1 each clock where ifid_flush=1.
  - Both saturate at all-ones, never wrap, and count only while rst=1.
- Register x0 never creates a hazard or a forward.

Decomposition:
- Shared package: state encoding (RUN/FLUSH/MEM_WAIT) and forward-select encodings (FWD_RF/FWD_WB/FWD_MEM), reused by the datapath muxes.
- One sub-module, sat_counter (CNT_W, inc), instantiated twice.

Test Plan:
- Load-use:
  - Stimulus: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
  - Response: that cycle pc_we=0, ifid_we=0, idex_bubble=1. With ex_memread=0 the next cycle, RUN resumes. stall_cycles=1.
- Redirect with FLUSH_CYCLES=2:
  - Stimulus: one-cycle ex_redirect.
  - Response: ifid_flush=idex_bubble=1 for exactly 2 cycles, state RUN→FLUSH→RUN, flush_cycles=2.
- Memory wait during FLUSH:
  - Stimulus: dwait for 3 cycles in the first FLUSH cycle.
  - Response: all enables 0 for 3 cycles with state=10, then FLUSH resumes its 1 remaining cycle.
- Forwarding:
  - Stimulus: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 → fwd_a=10.
  - Stimulus: mem_rd=0 → fwd_a=01.
  - Stimulus: ex_rs1=0 → fwd_a=00.
- Priority:
  - Stimulus: ld_use, ex_redirect and dwait together.
  - Response: freeze only. After dmem_ready the redirect is taken and ld_use is ignored.
- Reset mid-FLUSH:
  - Stimulus: rst=0 asynchronously.
  - Response: state=RUN, counters=0 immediately. Saturation check: force 2047 stall cycles, then a further stall keeps stall_cycles=2047.

Source files
------------

// File: rtl/hazard_sched_pkg.sv
// Shared encodings for the hazard controller and the EX operand muxes it steers.
package hazard_sched_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The younger result (MEM) wins over the older one (WB).
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Pipeline-status inputs and register-control outputs of the hazard controller.
interface hazard_sched_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 11
);
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              ex_regwrite, ex_memread, ex_redirect;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic              mem_regwrite, wb_regwrite;
    logic              dmem_req, dmem_ready;

    logic              pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we;
    logic [1:0]        fwd_a, fwd_b, state;
    logic [CNT_W-1:0]  stall_cycles, flush_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_redirect,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, dmem_req, dmem_ready,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               fwd_a, fwd_b, state, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_redirect,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, dmem_req, dmem_ready,
        output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we,
               fwd_a, fwd_b, state, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/hazard_sched_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (inc_i && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sched.sv
// Per-cycle advance/hold/squash control for the 5-stage pipeline, plus EX forwarding
// selects and stall/flush performance counters.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 11,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    hazard_sched_if.slave  bus
);

    localparam int             FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    hz_state_e       state_q, state_d, saved_q, saved_d, eff_state;
    logic [FC_W-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
    logic            ld_use, dwait;
    logic            pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we;
    logic            mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;

    assign ld_use = bus.ex_memread && bus.ex_regwrite && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                     (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
    assign dwait  = bus.dmem_req && !bus.dmem_ready;

    // While frozen, the release decision is made as if still in the interrupted state.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q     : state_q;
    assign eff_cnt   = (state_q == MEM_WAIT) ? saved_cnt_q : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            saved_q     <= RUN;
            saved_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            saved_q     <= saved_d;
            saved_cnt_q <= saved_cnt_d;
        end
    end

    always_comb begin
        state_d     = eff_state;
        cnt_d       = eff_cnt;
        saved_d     = saved_q;
        saved_cnt_d = saved_cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (dwait) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
            state_d  = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                saved_d     = state_q;
                saved_cnt_d = cnt_q;
            end
        end else if (bus.ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FC_RELOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (eff_state == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (eff_cnt == FC_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = eff_cnt - FC_W'(1);
            end
        end else if (ld_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end

        if (!rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    assign mem_hit_a = bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs1);
    assign wb_hit_a  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == bus.ex_rs1);
    assign mem_hit_b = bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs2);
    assign wb_hit_b  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == bus.ex_rs2);

    assign bus.fwd_a       = rst ? fwd_select(mem_hit_a, wb_hit_a) : FWD_RF;
    assign bus.fwd_b       = rst ? fwd_select(mem_hit_b, wb_hit_b) : FWD_RF;
    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_we    = exmem_we;
    assign bus.state       = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (!pc_we),
        .cnt_o (bus.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (ifid_flush),
        .cnt_o (bus.flush_cycles)
    );

endmodule

// File: tb/tb_hazard_sched.sv
// Directed-vector bench for hazard_sched with hand-computed expectations.
module tb_hazard_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    hazard_sched_if #(.REG_AW(5), .CNT_W(11)) hif ();

    hazard_sched #(.REG_AW(5), .CNT_W(11), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        hif.id_rs1 = '0;       hif.id_rs2 = '0;
        hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
        hif.ex_rs1 = '0;       hif.ex_rs2 = '0;      hif.ex_rd = '0;
        hif.ex_regwrite = 1'b0; hif.ex_memread = 1'b0; hif.ex_redirect = 1'b0;
        hif.mem_rd = '0;       hif.mem_regwrite = 1'b0;
        hif.wb_rd = '0;        hif.wb_regwrite = 1'b0;
        hif.dmem_req = 1'b0;   hif.dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld_use(input logic [4:0] rd, input logic [4:0] rs2, input logic use2);
        hif.ex_memread = 1'b1; hif.ex_regwrite = 1'b1;
        hif.ex_rd = rd; hif.id_rs2 = rs2; hif.id_use_rs2 = use2;
    endtask

    // pc_we, ifid_we, exmem_we, ifid_flush, idex_bubble, state
    task automatic chk_ctl(input string tag, input logic [1:0] st,
                           input logic pc, input logic ifid, input logic exm,
                           input logic fl, input logic bub);
        chk({tag, ".state"},  32'(hif.state),       32'(st));
        chk({tag, ".pc_we"},  32'(hif.pc_we),       32'(pc));
        chk({tag, ".ifid_we"},32'(hif.ifid_we),     32'(ifid));
        chk({tag, ".exmem"},  32'(hif.exmem_we),    32'(exm));
        chk({tag, ".flush"},  32'(hif.ifid_flush),  32'(fl));
        chk({tag, ".bubble"}, 32'(hif.idex_bubble), 32'(bub));
    endtask

    initial begin
        idle();
        hif.mem_rd = 5'd7; hif.mem_regwrite = 1'b1; hif.ex_rs1 = 5'd7;
        #2;
        chk_ctl("reset", 2'b00, 0, 0, 0, 1, 1);
        chk("reset.fwd_a", 32'(hif.fwd_a), 0);
        chk("reset.stall", 32'(hif.stall_cycles), 0);
        chk("reset.flushc", 32'(hif.flush_cycles), 0);

        tick();
        rst = 1'b1;
        idle();
        #2;
        chk_ctl("run", 2'b00, 1, 1, 1, 0, 0);

        // x0 and unused-operand matches never stall
        tick(); set_ld_use(5'd0, 5'd0, 1'b1); #2;
        chk("x0_nostall", 32'(hif.pc_we), 1);
        tick(); set_ld_use(5'd5, 5'd5, 1'b0); #2;
        chk("nouse_nostall", 32'(hif.pc_we), 1);

        tick(); set_ld_use(5'd5, 5'd5, 1'b1); #2;
        chk_ctl("lduse", 2'b00, 0, 0, 1, 0, 1);
        tick(); hif.ex_memread = 1'b0; #2;
        chk_ctl("lduse_after", 2'b00, 1, 1, 1, 0, 0);
        chk("lduse.stall", 32'(hif.stall_cycles), 1);

        tick(); idle(); hif.ex_redirect = 1'b1; #2;
        chk_ctl("redir0", 2'b00, 1, 1, 1, 1, 1);
        tick(); idle(); #2;
        chk_ctl("redir1", 2'b01, 1, 1, 1, 1, 1);
        tick(); #2;
        chk_ctl("redir2", 2'b00, 1, 1, 1, 0, 0);
        chk("redir.flushc", 32'(hif.flush_cycles), 2);

        // Freeze in the first FLUSH cycle, then resume the remaining flush cycle
        hif.ex_redirect = 1'b1;
        tick(); idle(); hif.dmem_req = 1'b1; #2;
        chk_ctl("fw0", 2'b01, 0, 0, 0, 0, 0);
        tick(); #2;
        chk_ctl("fw1", 2'b10, 0, 0, 0, 0, 0);
        tick(); #2;
        chk_ctl("fw2", 2'b10, 0, 0, 0, 0, 0);
        tick(); hif.dmem_ready = 1'b1; #2;
        chk_ctl("fw_rel", 2'b10, 1, 1, 1, 1, 1);
        tick(); idle(); #2;
        chk_ctl("fw_done", 2'b00, 1, 1, 1, 0, 0);
        chk("fw.stall", 32'(hif.stall_cycles), 4);
        chk("fw.flushc", 32'(hif.flush_cycles), 4);

        hif.mem_rd = 5'd7; hif.wb_rd = 5'd7; hif.ex_rs1 = 5'd7;
        hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1; #2;
        chk("fwd_mem", 32'(hif.fwd_a), 2);
        hif.mem_rd = 5'd0; #2;
        chk("fwd_wb", 32'(hif.fwd_a), 1);
        hif.ex_rs1 = 5'd0; #2;
        chk("fwd_x0", 32'(hif.fwd_a), 0);
        hif.mem_rd = 5'd9; hif.ex_rs2 = 5'd9; hif.wb_rd = 5'd9; #2;
        chk("fwdb_mem", 32'(hif.fwd_b), 2);
        hif.mem_regwrite = 1'b0; #2;
        chk("fwdb_wb", 32'(hif.fwd_b), 1);

        // dwait > redirect > ld_use
        tick(); idle();
        set_ld_use(5'd5, 5'd5, 1'b1);
        hif.ex_redirect = 1'b1; hif.dmem_req = 1'b1; #2;
        chk_ctl("pri0", 2'b00, 0, 0, 0, 0, 0);
        tick(); #2;
        chk_ctl("pri1", 2'b10, 0, 0, 0, 0, 0);
        tick(); hif.dmem_ready = 1'b1; #2;
        chk_ctl("pri_rel", 2'b10, 1, 1, 1, 1, 1);
        tick(); idle(); #2;
        chk_ctl("pri_flush", 2'b01, 1, 1, 1, 1, 1);
        chk("pri.stall", 32'(hif.stall_cycles), 6);
        chk("pri.flushc", 32'(hif.flush_cycles), 5);

        rst = 1'b0; #1;
        chk_ctl("arst", 2'b00, 0, 0, 0, 1, 1);
        chk("arst.stall", 32'(hif.stall_cycles), 0);
        chk("arst.flushc", 32'(hif.flush_cycles), 0);

        tick(); rst = 1'b1; hif.dmem_req = 1'b1;
        for (int i = 0; i < 2046; i++) tick();
        #2;
        chk("sat.2046", 32'(hif.stall_cycles), 2046);
        tick(); #2;
        chk("sat.2047", 32'(hif.stall_cycles), 2047);
        for (int i = 0; i < 3; i++) tick();
        #2;
        chk("sat.hold", 32'(hif.stall_cycles), 2047);
        chk("sat.flushc", 32'(hif.flush_cycles), 0);
        chk("sat.state", 32'(hif.state), 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
